// File: rtl/shifter_pkg.sv
// Shared types and defaults for the iterative right shifter.
package shifter_pkg;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;
  localparam int STRIDE      = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/shift_right_step.sv
// One combinational right-shift step: by 1, or by STRIDE when i_by4 is set.
module shift_right_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_fill,
  input  logic             i_by4,
  output logic [WIDTH-1:0] o_data
);

  assign o_data = i_by4 ? {{STRIDE{i_fill}}, i_data[WIDTH-1:STRIDE]}
                        : {i_fill, i_data[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_iter_32.sv
// Multi-cycle SRL/SRA unit: one bit per cycle, or 4 bits per cycle while
// count>=4 when SHIFT_STRIDE4_EN is defined (results identical either way).
module shift_right_iter_32
  import shifter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               arith_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   data_o
);

  state_e             r_state, w_state_nxt;
  logic [SHAMT_W-1:0] r_count;
  logic               r_sign;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   w_step;
  logic [SHAMT_W-1:0] w_dec;
  logic               w_by4;
  logic               w_accept;

`ifdef SHIFT_STRIDE4_EN
  assign w_by4 = (r_count >= SHAMT_W'(STRIDE));
`else
  assign w_by4 = 1'b0;
`endif

  assign w_dec    = w_by4 ? SHAMT_W'(STRIDE) : SHAMT_W'(1);
  assign w_accept = start_i && (r_state != SHIFT);

  shift_right_step #(.WIDTH(WIDTH)) u_step (
    .i_data (r_data),
    .i_fill (r_sign),
    .i_by4  (w_by4),
    .o_data (w_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start_i) w_state_nxt = (shamt_i != '0) ? SHIFT : DONE;
        else         w_state_nxt = IDLE;
      end
      // Leave SHIFT on the step that drains the count to zero.
      SHIFT:   if (r_count == w_dec) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_count <= '0;
      r_sign  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data  <= data_i;
        r_count <= shamt_i;
        r_sign  <= arith_i & data_i[WIDTH-1];
      end else if (r_state == SHIFT) begin
        r_data  <= w_step;
        r_count <= r_count - w_dec;
      end
    end
  end

  assign busy_o = (r_state == SHIFT);
  assign done_o = (r_state == DONE);
  assign data_o = r_data;

endmodule

// File: tb/tb_shift_right_iter_32.sv
// Scoreboard bench for shift_right_iter_32: driver pushes expected result and
// completion cycle, monitor pops on done_o.
module tb_shift_right_iter_32;
  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, arith_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic [SW-1:0] shamt_i = '0;
  logic          busy_o, done_o;
  logic [W-1:0]  data_o;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
    int           busy;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0, n_chk = 0, n_fail = 0, busy_cnt = 0;

  shift_right_iter_32 dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .data_i(data_i),
    .shamt_i(shamt_i), .arith_i(arith_i),
    .busy_o(busy_o), .done_o(done_o), .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_shift(logic [W-1:0] d, int k, bit a);
    logic signed [W-1:0] s;
    s = d;
    if (a) return W'(s >>> k);
    return d >> k;
  endfunction

  function automatic int ref_lat(int k);
`ifdef SHIFT_STRIDE4_EN
    return k / 4 + k % 4;
`else
    return k;
`endif
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called just after a negedge; a start seen with busy_o low is taken at the next edge.
  task automatic drive(input bit st, input logic [W-1:0] d, input int k,
                       input bit a, output bit acc);
    start_i = st; data_i = d; shamt_i = SW'(k); arith_i = a;
    acc = st && !busy_o && rst_i;
    if (acc) sb.push_back('{ref_shift(d, k, a), cyc + 1 + ref_lat(k), ref_lat(k)});
  endtask

  task automatic op(input logic [W-1:0] d, input int k, input bit a);
    int g = 0;
    bit acc;
    @(negedge clk_i);
    while (busy_o && g < 200) begin @(negedge clk_i); g++; end
    drive(1'b1, d, k, a, acc);
    @(negedge clk_i);
    drive(1'b0, '0, 0, 1'b0, acc);
  endtask

  task automatic wait_done(input string nm, input logic [W-1:0] exp);
    int g = 0;
    while (!done_o && g < 100) begin @(negedge clk_i); g++; end
    if (!done_o) check({nm, "_timeout"}, 64'(g), 64'(0));
    else         check(nm, 64'(data_o), 64'(exp));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i) busy_cnt = 0;
      else begin
        if (busy_o) busy_cnt++;
        if (done_o) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_done: got done_o=1 required no pending op");
          end else begin
            e = sb.pop_front();
            check("sb_data", 64'(data_o), 64'(e.data));
            check("sb_done_cycle", 64'(cyc), 64'(e.cyc));
            check("sb_busy_cycles", 64'(busy_cnt), 64'(e.busy));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin : stim
    bit acc;
    int g, k, issued;
    #2 rst_i = 1'b0;
    #1;
    check("rst_data", 64'(data_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    @(negedge clk_i); rst_i = 1'b1;

    // SRL, SRA with full-width fill, and zero shift
    op(32'h8000_0000, 4, 1'b0);   wait_done("srl4", 32'h0800_0000);
    op(32'h8000_00F0, 31, 1'b1);  wait_done("sra31", 32'hFFFF_FFFF);
    op(32'h1234_5678, 0, 1'b0);
    check("k0_done_next", 64'(done_o), 64'(1));
    wait_done("k0", 32'h1234_5678);
    op(32'h7000_0000, 8, 1'b1);   wait_done("sra_pos", 32'h0070_0000);

    // Start held high through SHIFT: only the DONE-cycle start is taken
    @(negedge clk_i);
    while (busy_o) @(negedge clk_i);
    drive(1'b1, 32'h0000_FF00, 6, 1'b0, acc);
    g = 0;
    do begin
      @(negedge clk_i);
      drive(1'b1, 32'h8000_0000, 3, 1'b1, acc);
      g++;
    end while (!acc && g < 100);
    check("held_first", 64'(data_o), 64'(32'h0000_03FC));
    check("held_in_done", 64'(done_o), 64'(1));
    @(negedge clk_i);
    drive(1'b0, '0, 0, 1'b0, acc);
    wait_done("held_second", 32'hF000_0000);

    // Asynchronous reset mid-shift abandons the op
    op(32'hDEAD_BEEF, 20, 1'b1);
    repeat (6) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("midrst_data", 64'(data_o), 64'(0));
    check("midrst_busy", 64'(busy_o), 64'(0));
    check("midrst_done", 64'(done_o), 64'(0));
    sb.delete();
    @(negedge clk_i); rst_i = 1'b1;
    op(32'hDEAD_BEEF, 20, 1'b1);  wait_done("after_rst", 32'hFFFF_FDEA);

    // Random back-to-back traffic; starts during SHIFT carry junk and are ignored
    issued = 0;
    for (int c = 0; c < 40000 && issued < 1000; c++) begin
      @(negedge clk_i);
      k = ($urandom % 8 == 0) ? (($urandom % 2 == 1) ? 0 : 31) : int'($urandom % 32);
      drive(($urandom % 4) != 0, $urandom, k, 1'($urandom % 2), acc);
      if (acc) issued++;
    end
    @(negedge clk_i);
    drive(1'b0, '0, 0, 1'b0, acc);
    check("random_issued", 64'(issued), 64'(1000));

    g = 0;
    while (sb.size() != 0 && g < 200) begin @(negedge clk_i); g++; end
    check("drain_pending", 64'(sb.size()), 64'(0));
    repeat (2) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
